// File: rtl/spart_fifo_if.sv
// spart_fifo_if: processor-side access strobes, status handshake and serial line of the SPART.
// The 8-bit data bus is a bidirectional wire, so it stays a plain module port.
interface spart_fifo_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;

    modport master (output iocs, iorw, ioaddr, rxd, input rda, tbr, txd);
    modport slave  (input iocs, iorw, ioaddr, rxd, output rda, tbr, txd);
endinterface

// File: rtl/spart_fifo.sv
// spart_fifo: buffered SPART with TX/RX FIFOs, programmable 16-bit baud divisor
// (16 ticks per bit), optional parity, optional second stop bit and sticky error flags.
module spart_fifo #(
    parameter int          DATA_BITS   = 8,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd650
) (
    input  logic         clk,
    input  logic         rst,
    spart_fifo_if.slave  bus,
    inout  wire  [7:0]   databus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Configuration and sticky flags ([0] overrun, [1] parity, [2] framing)
    logic [15:0] r_div, r_baud_cnt;
    logic [2:0]  r_ctrl;
    logic [2:0]  r_flags;

    // FIFO storage and pointers (one extra wrap bit for full/empty)
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW:0]          r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;

    // TX state
    state_t               r_tx_state;
    logic [3:0]           r_tx_tcnt;
    logic [2:0]           r_tx_bit;
    logic                 r_tx_arm, r_tx_stop2, r_tx_par, r_txd;
    logic [DATA_BITS-1:0] r_tx_shift;

    // RX state
    state_t               r_rx_state;
    logic [3:0]           r_rx_tcnt;
    logic [2:0]           r_rx_bit;
    logic                 r_rx_s1, r_rx_s2, r_rx_s3, r_rx_par;
    logic [DATA_BITS-1:0] r_rx_shift;

    logic                 w_rd, w_wr, w_stat_rd, w_div_wr, w_tick;
    logic                 w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic                 w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic                 w_tx_stop_end, w_tx_idle;
    logic                 w_rx_stop_smp, w_rx_fall, w_rx_par_ok;
    logic [2:0]           w_flag_set;
    logic [DATA_BITS-1:0] w_tx_head, w_rx_head;
    logic [7:0]           w_status, w_rd_data;

    // ---------------- bus decode ----------------
    assign w_rd      = bus.iocs & bus.iorw;
    assign w_wr      = bus.iocs & ~bus.iorw;
    assign w_stat_rd = w_rd & (bus.ioaddr == 2'b01);
    assign w_div_wr  = w_wr & bus.ioaddr[1];

    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
    assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rd[AW-1:0]];
    assign w_rx_head  = r_rx_mem[r_rx_rd[AW-1:0]];

    // A full FIFO still accepts a push when it is popped in the same cycle
    assign w_rx_pop  = w_rd & (bus.ioaddr == 2'b00) & ~w_rx_empty;
    assign w_tx_push = w_wr & (bus.ioaddr == 2'b00) & (~w_tx_full | w_tx_pop);

    assign w_tx_idle = w_tx_empty && (r_tx_state == S_IDLE);
    assign w_status  = {2'b00, w_tx_idle, r_flags, ~w_tx_full, ~w_rx_empty};

    assign bus.rda = ~w_rx_empty;
    assign bus.tbr = ~w_tx_full;
    assign bus.txd = r_txd;

    // Combinational read mux; an empty RX FIFO reads as zero
    always_comb begin
        w_rd_data = 8'h00;
        if (bus.ioaddr == 2'b01)
            w_rd_data = w_status;
        else if (!w_rx_empty)
            w_rd_data = 8'(w_rx_head);
    end

    assign databus = (w_rd && !bus.ioaddr[1]) ? w_rd_data : 8'bz;

    // Control and divisor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= DEFAULT_DIV;
            r_ctrl <= 3'b000;
        end else if (w_wr) begin
            case (bus.ioaddr)
                2'b01:   r_ctrl      <= databus[2:0];
                2'b10:   r_div[7:0]  <= databus;
                2'b11:   r_div[15:8] <= databus;
                default: ;
            endcase
        end
    end

    // Baud tick generator: counts 0..divisor, restarts on any divisor write
    assign w_tick = (r_baud_cnt == r_div);
    always_ff @(posedge clk) begin
        if (rst || w_div_wr || w_tick) r_baud_cnt <= 16'd0;
        else                           r_baud_cnt <= r_baud_cnt + 16'd1;
    end

    // FIFO data arrays (no reset needed on storage)
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= databus[DATA_BITS-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= r_rx_shift;
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wr <= '0; r_tx_rd <= '0; r_rx_wr <= '0; r_rx_rd <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
        end
    end

    // Sticky error flags: a status read clears them, a same-cycle event wins
    assign w_flag_set[0] = w_rx_stop_smp && r_rx_s2 && w_rx_full && !w_rx_pop;
    assign w_flag_set[1] = w_rx_push && !w_rx_par_ok;
    assign w_flag_set[2] = w_rx_stop_smp && !r_rx_s2;
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) r_flags[i] <= 1'b0;
            else     r_flags[i] <= (r_flags[i] & ~w_stat_rd) | w_flag_set[i];
        end
    end

    // ---------------- transmitter ----------------
    // A character is fetched from IDLE or, for back-to-back frames, at the end of STOP
    assign w_tx_stop_end = (r_tx_state == S_STOP) && w_tick && (r_tx_tcnt == 4'd15)
                           && (!r_ctrl[2] || r_tx_stop2);
    assign w_tx_pop      = !w_tx_empty && ((r_tx_state == S_IDLE) || w_tx_stop_end);

    // TX FSM; every line transition happens on a tick edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE; r_txd <= 1'b1; r_tx_arm <= 1'b0; r_tx_tcnt <= 4'd0;
            r_tx_bit <= 3'd0; r_tx_stop2 <= 1'b0; r_tx_par <= 1'b0; r_tx_shift <= '0;
        end else if (w_tx_pop) begin
            // Start bit begins now if this is a tick, otherwise wait armed for the next one
            r_tx_shift <= w_tx_head;
            r_tx_par   <= (^w_tx_head) ^ r_ctrl[1];
            r_tx_state <= S_START;
            r_tx_tcnt  <= 4'd0;
            r_tx_stop2 <= 1'b0;
            r_tx_arm   <= ~w_tick;
            r_txd      <= ~w_tick;
        end else if (w_tick) begin
            case (r_tx_state)
                S_START: begin
                    if (r_tx_arm) begin
                        r_tx_arm <= 1'b0; r_txd <= 1'b0; r_tx_tcnt <= 4'd0;
                    end else if (r_tx_tcnt == 4'd15) begin
                        r_tx_tcnt <= 4'd0; r_tx_bit <= 3'd0;
                        r_txd <= r_tx_shift[0]; r_tx_state <= S_DATA;
                    end else r_tx_tcnt <= r_tx_tcnt + 4'd1;
                end
                S_DATA: begin
                    if (r_tx_tcnt == 4'd15) begin
                        r_tx_tcnt <= 4'd0;
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx_state <= r_ctrl[0] ? S_PARITY : S_STOP;
                            r_txd      <= r_ctrl[0] ? r_tx_par : 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                        end
                    end else r_tx_tcnt <= r_tx_tcnt + 4'd1;
                end
                S_PARITY: begin
                    if (r_tx_tcnt == 4'd15) begin
                        r_tx_tcnt <= 4'd0; r_txd <= 1'b1; r_tx_state <= S_STOP;
                    end else r_tx_tcnt <= r_tx_tcnt + 4'd1;
                end
                S_STOP: begin
                    if (r_tx_tcnt == 4'd15) begin
                        r_tx_tcnt <= 4'd0;
                        if (r_ctrl[2] && !r_tx_stop2) r_tx_stop2 <= 1'b1;
                        else                          r_tx_state <= S_IDLE;
                    end else r_tx_tcnt <= r_tx_tcnt + 4'd1;
                end
                default: r_txd <= 1'b1;
            endcase
        end
    end

    // ---------------- receiver ----------------
    assign w_rx_fall     = r_rx_s3 & ~r_rx_s2;
    assign w_rx_stop_smp = (r_rx_state == S_STOP) && w_tick && (r_rx_tcnt == 4'd15);
    assign w_rx_par_ok   = !r_ctrl[0] || (r_rx_par == ((^r_rx_shift) ^ r_ctrl[1]));
    assign w_rx_push     = w_rx_stop_smp && r_rx_s2 && (!w_rx_full || w_rx_pop);

    // rxd synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
        else     {r_rx_s1, r_rx_s2, r_rx_s3} <= {bus.rxd, r_rx_s1, r_rx_s2};
    end

    // RX FSM: mid-start check at tick 8, then one sample every 16 ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= S_IDLE; r_rx_tcnt <= 4'd0; r_rx_bit <= 3'd0;
            r_rx_par <= 1'b0; r_rx_shift <= '0;
        end else if (r_rx_state == S_IDLE) begin
            if (w_rx_fall) begin
                r_rx_state <= S_START; r_rx_tcnt <= 4'd0;
            end
        end else if (w_tick) begin
            case (r_rx_state)
                S_START: begin
                    if (r_rx_tcnt == 4'd7) begin
                        r_rx_tcnt <= 4'd0; r_rx_bit <= 3'd0;
                        r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else r_rx_tcnt <= r_rx_tcnt + 4'd1;
                end
                S_DATA: begin
                    if (r_rx_tcnt == 4'd15) begin
                        r_rx_tcnt  <= 4'd0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == LAST_BIT) r_rx_state <= r_ctrl[0] ? S_PARITY : S_STOP;
                        else                      r_rx_bit   <= r_rx_bit + 3'd1;
                    end else r_rx_tcnt <= r_rx_tcnt + 4'd1;
                end
                S_PARITY: begin
                    if (r_rx_tcnt == 4'd15) begin
                        r_rx_tcnt <= 4'd0; r_rx_par <= r_rx_s2; r_rx_state <= S_STOP;
                    end else r_rx_tcnt <= r_rx_tcnt + 4'd1;
                end
                S_STOP: begin
                    if (r_rx_tcnt == 4'd15) begin
                        r_rx_tcnt <= 4'd0; r_rx_state <= S_IDLE;
                    end else r_rx_tcnt <= r_rx_tcnt + 4'd1;
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo: scoreboard bench for spart_fifo (TX framing, loopback with parity,
// FIFO full/drop, overrun, framing/parity errors, false start, divisor and reset mid-frame).
module tb_spart_fifo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spart_fifo_if bif();
    wire  [7:0] databus;
    logic       tb_drv;
    logic [7:0] tb_wdata;
    logic       loopback;
    logic       tb_rxd;

    assign databus = tb_drv ? tb_wdata : 8'bz;
    assign bif.rxd = loopback ? bif.txd : tb_rxd;

    spart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd650)) dut (
        .clk(clk), .rst(rst), .bus(bif), .databus(databus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bif.iocs = 1'b1; bif.iorw = 1'b0; bif.ioaddr = a; tb_wdata = d; tb_drv = 1'b1;
        @(negedge clk);
        bif.iocs = 1'b0; tb_drv = 1'b0;
        $display("[%0t] write addr=%0d data=%02h", $time, a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bif.iocs = 1'b1; bif.iorw = 1'b1; bif.ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        bif.iocs = 1'b0; bif.iorw = 1'b0;
        $display("[%0t] read  addr=%0d data=%02h", $time, a, d);
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Pop the oldest expected character and compare it with an RX FIFO read
    task automatic rx_expect_read(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus_read(2'b00, d);
            check(tag, d, e);
        end
    endtask

    task automatic wait_rda(input string tag, input int budget);
        int k = 0;
        while (bif.rda !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        check(tag, bif.rda, 1'b1);
    endtask

    task automatic wait_txd_low(input string tag, input int budget);
        int k = 0;
        while (bif.txd !== 1'b0 && k < budget) begin @(negedge clk); k++; end
        check(tag, bif.txd, 1'b0);
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (bif.txd === 1'b0 && n < 400) begin n++; @(negedge clk); end
    endtask

    // Bit-banged RX frame at divisor 0 (16 clocks per bit), 8 data bits
    task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop_bit);
        @(negedge clk);
        tb_rxd = 1'b0; repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin tb_rxd = d[i]; repeat (16) @(negedge clk); end
        if (par_en) begin tb_rxd = par_bit; repeat (16) @(negedge clk); end
        tb_rxd = stop_bit; repeat (16) @(negedge clk);
        tb_rxd = 1'b1; repeat (16) @(negedge clk);
        $display("[%0t] rx frame data=%02h par_en=%0d par=%0d stop=%0d", $time, d, par_en, par_bit, stop_bit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int         n;

        rst = 1'b1; bif.iocs = 1'b0; bif.iorw = 1'b0; bif.ioaddr = 2'b00;
        tb_drv = 1'b0; tb_wdata = 8'h00; loopback = 1'b0; tb_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txd", bif.txd, 1'b1);
        check("rst_rda", bif.rda, 1'b0);
        check("rst_tbr", bif.tbr, 1'b1);
        rst = 1'b0;
        read_check("rst_status", 2'b01, 8'h22);

        // Single TX frame at divisor 0: 16 clocks per bit
        bus_write(2'b10, 8'h00);
        bus_write(2'b11, 8'h00);
        bus_write(2'b00, 8'hA5);
        wait_txd_low("tx_start_seen", 20);
        count_low(n);
        check("tx_start_len", 16'(n), 16'd16);
        pat = 8'hA5;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_bit%0d", i), bif.txd, pat[i]);
            repeat (16) @(negedge clk);
        end
        check("tx_stop", bif.txd, 1'b1);
        repeat (20) @(negedge clk);
        read_check("tx_idle_status", 2'b01, 8'h22);

        // Loopback with odd parity; TX FIFO fills behind the character in flight
        bus_write(2'b01, 8'h03);
        loopback = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_write(2'b00, 8'(i));
            exp_q.push_back(8'(i));
        end
        check("fill_tbr_full", bif.tbr, 1'b0);
        bus_write(2'b00, 8'h55);              // dropped: FIFO full
        check("fill_tbr_still_full", bif.tbr, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_rda($sformatf("lb_rda%0d", i), 400);
            rx_expect_read($sformatf("lb_data%0d", i));
        end
        repeat (400) @(negedge clk);
        check("lb_rda_empty", bif.rda, 1'b0);
        read_check("lb_empty_read", 2'b00, 8'h00);
        read_check("lb_status", 2'b01, 8'h22);

        // Overrun: five frames, no reads in between
        for (int i = 0; i < 4; i++) begin
            bus_write(2'b00, 8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        bus_write(2'b00, 8'h7E);
        repeat (1100) @(negedge clk);
        read_check("ovr_status1", 2'b01, 8'h27);
        read_check("ovr_status2", 2'b01, 8'h23);
        for (int i = 0; i < 4; i++) rx_expect_read($sformatf("ovr_data%0d", i));
        read_check("ovr_empty_read", 2'b00, 8'h00);
        check("ovr_rda_empty", bif.rda, 1'b0);

        // Framing error, parity good/bad, false start
        loopback = 1'b0;
        bus_write(2'b01, 8'h00);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check("frm_rda", bif.rda, 1'b0);
        read_check("frm_status", 2'b01, 8'h32);
        read_check("frm_cleared", 2'b01, 8'h22);

        bus_write(2'b01, 8'h01);              // even parity
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(8'hC3);
        read_check("par_ok_status", 2'b01, 8'h23);
        rx_expect_read("par_ok_data");
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(8'h01);
        read_check("par_err_status", 2'b01, 8'h2B);
        rx_expect_read("par_err_data");

        @(negedge clk);
        tb_rxd = 1'b0; repeat (4) @(negedge clk);
        tb_rxd = 1'b1; repeat (40) @(negedge clk);
        $display("[%0t] rx glitch 4 ticks", $time);
        check("glitch_rda", bif.rda, 1'b0);
        read_check("glitch_status", 2'b01, 8'h22);

        // Divisor 3 (64-clock bits), then reset in the middle of a frame
        bus_write(2'b01, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);  // left unread, must be flushed by reset
        check("pre_rst_rda", bif.rda, 1'b1);
        bus_write(2'b10, 8'h03);
        bus_write(2'b11, 8'h00);
        bus_write(2'b00, 8'h01);
        wait_txd_low("div3_start_seen", 6);
        count_low(n);
        check("div3_start_len", 16'(n), 16'd64);
        bus_write(2'b00, 8'h02);
        repeat (64) @(negedge clk);
        check("mid_frame_txd", bif.txd, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_txd", bif.txd, 1'b1);
        check("mid_rst_rda", bif.rda, 1'b0);
        check("mid_rst_tbr", bif.tbr, 1'b1);
        rst = 1'b0;
        read_check("mid_rst_status", 2'b01, 8'h22);
        read_check("mid_rst_rx_empty", 2'b00, 8'h00);
        repeat (50) @(negedge clk);
        check("mid_rst_txd_quiet", bif.txd, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
